ov5640_frame_capture: RTL and testbench
=======================================

Name: ov5640_frame_capture

Overview:
- Capture stage directly upstream of the VGA readout controller.
- Samples the OV5640 8-bit DVP stream (RGB565, two bytes per pixel) and crops it to axil_cap_width x axil_cap_height.
- Writes exactly one frame into the shared frame BRAM at linear address x + y*width, then raises axil_capture_done, which gates the VGA readout.
- Single-shot per start request; optional frame skipping lets auto-exposure settle.

Parameters:
- SKIP_FRAMES, 0: number of complete frames discarded after start before one is captured.
- VSYNC_ACT_HIGH, 1: 1 means the cam_vsync rising edge marks frame start; 0 means the falling edge does.
- BRAM_DEPTH, 131072: number of BRAM words; writes at address >= BRAM_DEPTH are suppressed.

Ports:
- cam_pclk  in  1  camera pixel clock; sole clock of the block.
- sys_rst  in  1  asynchronous, active-low reset.
- cam_vsync  in  1  DVP frame sync.
- cam_href  in  1  DVP line valid.
- cam_data  in  8  DVP byte.
- axil_capture_start  in  1  one-cycle start request.
- axil_cap_width  in  9  crop width in pixels.
- axil_cap_height  in  9  crop height in lines.
- axil_capture_busy  out  1  high from accepted start until done.
- axil_capture_done  out  1  level; frame in BRAM is valid.
- cam_bram_waddr  out  17  BRAM write address.
- cam_bram_wdata  out  16  RGB565 pixel.
- cam_bram_wen  out  1  BRAM write enable.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Input capture: cam_vsync, cam_href and cam_data are registered once on cam_pclk. Edges are detected on the registered copies.
- Frame edge: the active vsync edge per VSYNC_ACT_HIGH.
- States:
  - IDLE: waiting for a start request.
  - WAIT_VS: waiting for a frame edge.
  - SKIP: discarding frames.
  - CAPTURE: writing pixels.
  - DONE: frame valid.
- Transitions:
  - IDLE or DONE -> WAIT_VS on axil_capture_start. On that cycle width and height are latched, done is cleared and busy is set. Start is ignored in WAIT_VS, SKIP and CAPTURE.
  - WAIT_VS -> SKIP on a frame edge if SKIP_FRAMES > 0, else WAIT_VS -> CAPTURE. The skip counter loads SKIP_FRAMES.
  - SKIP: the counter decrements on each frame edge. When it reaches 0 on a frame edge, go to CAPTURE.
  - CAPTURE -> DONE on the next frame edge, or once y reaches the latched height. In DONE, busy=0 and done=1, held until the next start.
  - Latched width = 0 or height = 0: CAPTURE -> DONE on the next frame edge with zero writes.
- Byte assembly (CAPTURE only): within href high, bytes alternate high then low. The phase is reset while href is low. A trailing odd byte at line end is discarded.
- Pixel write: after the low byte is sampled, and only if x < width and y < height:
  - wen pulses for 1 cycle, one cycle after the low-byte sample;
  - wdata = {high, low};
  - waddr = running linear address.
- Address is incremental with no multiplier: it increments by 1 per written pixel. Pixels with x >= width are dropped without advancing the address, so line y starts at y*width.
- x (10 bits) increments per assembled pixel and saturates at 1023. On the href falling edge, x clears; y (10 bits) increments only if x > 0.
- Address guard: a write with address >= BRAM_DEPTH is suppressed (wen stays 0). This leaves width*height > BRAM_DEPTH safe.
- A frame edge in the same cycle as a pixel write: the write completes, then the state moves to DONE.
- A start in the same cycle as a DONE entry is ignored.
- Reset mid-capture: immediate return to IDLE. done=0, wen=0, and partial BRAM contents are not flagged valid.
- Clock domain: done is a level in the cam_pclk domain. The VGA consumer synchronises it; done stays stable until the next start.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, WAIT_VS, SKIP, CAPTURE, DONE);
  - BRAM_ADDR_W = 17, PIX_W = 16, DIM_W = 9;
  - RGB565 field positions, shared with the VGA side.
- One natural sub-module, dvp_byte_pack: registers the inputs, detects edges, assembles byte pairs into pixels, and emits pixel_valid, pixel, line_end and frame_edge.
- The capture FSM, counters and address generation remain in the top.

Test Plan:
- Width 4, height 3, SKIP_FRAMES 0; start, then a frame of 6 lines x 8 pixels with data = incrementing bytes -> exactly 12 writes, addresses 0..11; first wdata 0x0001; done=1 after the next vsync edge; busy=0.
- Width 3, lines of 5 pixels -> line 1 starts at address 3; pixels at x=3 and x=4 are never written; 9 writes for height 3.
- SKIP_FRAMES 2 -> no wen during the first two frames after start; writes occur in the third frame only.
- Odd byte count per line (9 bytes) -> 4 pixels per line; the trailing byte is ignored; the next line starts on the high byte.
- Start pulsed mid-CAPTURE -> ignored; addresses continue monotonically. Start in DONE -> done drops the next cycle and a new capture begins.
- Reset asserted mid-line -> all outputs 0 asynchronously; after release, no writes occur without a new start.

Source files
------------

// File: rtl/ov5640_frame_capture_pkg.sv
// ov5640_frame_capture_pkg
// Shared definitions for the OV5640 capture stage: capture FSM state codes,
// bus widths, and the RGB565 field layout that the VGA readout side also uses.
package ov5640_frame_capture_pkg;

  localparam int BRAM_ADDR_W = 17;
  localparam int PIX_W       = 16;
  localparam int DIM_W       = 9;

  // RGB565 field positions inside a stored pixel word
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // Capture FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_VS = 3'd1;
  localparam logic [2:0] ST_SKIP    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // 10-bit increment that sticks at the top value instead of wrapping
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/ov5640_frame_capture_if.sv
// ov5640_frame_capture_if
// Frame BRAM write port driven by the capture stage.
//   cam_bram_waddr : word address (x + y*width)
//   cam_bram_wdata : RGB565 pixel
//   cam_bram_wen   : single-cycle write strobe
// master = capture stage, slave = BRAM / observer.
interface ov5640_frame_capture_if;
  import ov5640_frame_capture_pkg::*;

  logic [BRAM_ADDR_W-1:0] cam_bram_waddr;
  logic [PIX_W-1:0]       cam_bram_wdata;
  logic                   cam_bram_wen;

  modport master (output cam_bram_waddr, output cam_bram_wdata, output cam_bram_wen);
  modport slave  (input  cam_bram_waddr, input  cam_bram_wdata, input  cam_bram_wen);
endinterface

// File: rtl/ov5640_frame_capture_dvp_byte_pack.sv
// dvp_byte_pack
// Registers the raw DVP inputs once, detects href/vsync edges on the
// registered copies and pairs bytes (high first) into RGB565 pixels.
//   clk, rst_n     : camera pixel clock, async active-low reset
//   vsync/href/data: raw DVP inputs
//   enable         : byte pairing only runs while the top is capturing
//   pixel_valid    : high in the cycle the low byte is sampled
//   pixel          : {high, low} for that cycle
//   line_end       : href falling edge
//   frame_edge     : active vsync edge selected by VSYNC_ACT_HIGH
module dvp_byte_pack
  import ov5640_frame_capture_pkg::*;
#(
  parameter int VSYNC_ACT_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             href,
  input  logic [7:0]       data,
  input  logic             enable,
  output logic             pixel_valid,
  output logic [PIX_W-1:0] pixel,
  output logic             line_end,
  output logic             frame_edge
);

  logic       vsync_r, vsync_q, href_r, href_q, phase;
  logic [7:0] data_r, high_byte;

  // phase is 0 when the next byte is a high byte; it is forced back to 0
  // whenever href is low so an odd trailing byte never leaks into the next line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r   <= 1'b0;
      vsync_q   <= 1'b0;
      href_r    <= 1'b0;
      href_q    <= 1'b0;
      data_r    <= 8'd0;
      high_byte <= 8'd0;
      phase     <= 1'b0;
    end else begin
      vsync_r <= vsync;
      vsync_q <= vsync_r;
      href_r  <= href;
      href_q  <= href_r;
      data_r  <= data;
      if (!enable || !href_r) begin
        phase <= 1'b0;
      end else begin
        phase <= ~phase;
        if (!phase) high_byte <= data_r;
      end
    end
  end

  assign pixel_valid = enable & href_r & phase;
  assign pixel       = {high_byte, data_r};
  assign line_end    = href_q & ~href_r;
  assign frame_edge  = (VSYNC_ACT_HIGH != 0) ? (vsync_r & ~vsync_q) : (vsync_q & ~vsync_r);

endmodule

// File: rtl/ov5640_frame_capture.sv
// ov5640_frame_capture
// Single-shot OV5640 frame grabber: after a start request it optionally skips
// SKIP_FRAMES frames, then writes one cropped frame into the frame BRAM at
// x + y*width and raises axil_capture_done for the VGA readout.
//   cam_pclk, sys_rst           : pixel clock, async active-low reset
//   cam_vsync/cam_href/cam_data : DVP input
//   axil_capture_start          : one-cycle start request
//   axil_cap_width/height       : crop size, latched on an accepted start
//   axil_capture_busy/done      : status levels
//   bram                        : BRAM write port (master side)
module ov5640_frame_capture
  import ov5640_frame_capture_pkg::*;
#(
  parameter int SKIP_FRAMES    = 0,
  parameter int VSYNC_ACT_HIGH = 1,
  parameter int BRAM_DEPTH     = 131072
) (
  input  logic                 cam_pclk,
  input  logic                 sys_rst,
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic [7:0]           cam_data,
  input  logic                 axil_capture_start,
  input  logic [DIM_W-1:0]     axil_cap_width,
  input  logic [DIM_W-1:0]     axil_cap_height,
  output logic                 axil_capture_busy,
  output logic                 axil_capture_done,
  ov5640_frame_capture_if.master bram
);

  // one extra address bit so large crops keep counting past the guard
  // instead of wrapping back into valid BRAM space
  localparam logic [BRAM_ADDR_W:0] DEPTH_LIM = (BRAM_ADDR_W + 1)'(BRAM_DEPTH);
  localparam logic [15:0]          SKIP_INIT = 16'(SKIP_FRAMES);

  logic [2:0]             state;
  logic [DIM_W-1:0]       width_q, height_q;
  logic [9:0]             x, y;
  logic [BRAM_ADDR_W:0]   addr;
  logic [15:0]            skip_cnt;
  logic                   pixel_valid, line_end, frame_edge;
  logic [PIX_W-1:0]       pixel;
  logic                   in_window, early_done;

  dvp_byte_pack #(.VSYNC_ACT_HIGH(VSYNC_ACT_HIGH)) u_pack (
    .clk         (cam_pclk),
    .rst_n       (sys_rst),
    .vsync       (cam_vsync),
    .href        (cam_href),
    .data        (cam_data),
    .enable      (state == ST_CAPTURE),
    .pixel_valid (pixel_valid),
    .pixel       (pixel),
    .line_end    (line_end),
    .frame_edge  (frame_edge)
  );

  assign in_window  = (x < {1'b0, width_q}) && (y < {1'b0, height_q});
  // a zero-sized crop never finishes early; it waits for the frame edge
  assign early_done = (width_q != '0) && (height_q != '0) && (y >= {1'b0, height_q});

  // Capture FSM, position counters and the incremental write address.
  // The write port is registered, so wen lands one cycle after the low byte.
  always_ff @(posedge cam_pclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state               <= ST_IDLE;
      width_q             <= '0;
      height_q            <= '0;
      x                   <= '0;
      y                   <= '0;
      addr                <= '0;
      skip_cnt            <= '0;
      axil_capture_busy   <= 1'b0;
      axil_capture_done   <= 1'b0;
      bram.cam_bram_wen   <= 1'b0;
      bram.cam_bram_waddr <= '0;
      bram.cam_bram_wdata <= '0;
    end else begin
      bram.cam_bram_wen <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (axil_capture_start) begin
            state             <= ST_WAIT_VS;
            width_q           <= axil_cap_width;
            height_q          <= axil_cap_height;
            axil_capture_done <= 1'b0;
            axil_capture_busy <= 1'b1;
          end
        end
        ST_WAIT_VS: begin
          if (frame_edge) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
            if (SKIP_FRAMES > 0) begin
              state    <= ST_SKIP;
              skip_cnt <= SKIP_INIT;
            end else begin
              state <= ST_CAPTURE;
            end
          end
        end
        ST_SKIP: begin
          if (frame_edge) begin
            skip_cnt <= skip_cnt - 16'd1;
            if (skip_cnt == 16'd1) state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (pixel_valid) begin
            if (in_window) begin
              if (addr < DEPTH_LIM) begin
                bram.cam_bram_wen   <= 1'b1;
                bram.cam_bram_waddr <= addr[BRAM_ADDR_W-1:0];
                bram.cam_bram_wdata <= pixel;
              end
              addr <= addr + 1'b1;
            end
            x <= sat_inc10(x);
          end else if (line_end) begin
            x <= '0;
            if (x != '0) y <= sat_inc10(y);
          end
          // any write decided above still goes out; only the state moves on
          if (frame_edge || early_done) begin
            state             <= ST_DONE;
            axil_capture_busy <= 1'b0;
            axil_capture_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_frame_capture.sv
// tb_ov5640_frame_capture
// Drives synthetic DVP frames into two capture instances (no skip / full
// depth, and two skipped frames / 8-word BRAM) and compares every BRAM write
// with an address/data list computed directly from the crop rules.
module tb_ov5640_frame_capture;
  import ov5640_frame_capture_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       vsync = 1'b0, href = 1'b0;
  logic [7:0] data = 8'd0;
  logic       start0 = 1'b0, start2 = 1'b0;
  logic [8:0] width = 9'd0, height = 9'd0;
  logic       busy0, done0, busy2, done2;

  int tests_run = 0;
  int tests_failed = 0;
  int mid_start_line = -1;
  logic mid_busy;

  logic [32:0] got0[$], got2[$], exp_q[$];
  logic [7:0]  frame_bytes [0:15][0:15];

  always #5 clk = ~clk;

  ov5640_frame_capture_if bus0 ();
  ov5640_frame_capture_if bus2 ();

  ov5640_frame_capture #(.SKIP_FRAMES(0), .VSYNC_ACT_HIGH(1), .BRAM_DEPTH(131072)) dut0 (
    .cam_pclk(clk), .sys_rst(rst_n), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
    .axil_capture_start(start0), .axil_cap_width(width), .axil_cap_height(height),
    .axil_capture_busy(busy0), .axil_capture_done(done0), .bram(bus0));

  ov5640_frame_capture #(.SKIP_FRAMES(2), .VSYNC_ACT_HIGH(1), .BRAM_DEPTH(8)) dut2 (
    .cam_pclk(clk), .sys_rst(rst_n), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
    .axil_capture_start(start2), .axil_cap_width(width), .axil_cap_height(height),
    .axil_capture_busy(busy2), .axil_capture_done(done2), .bram(bus2));

  // write monitor, sampled away from the rising edge
  always @(negedge clk) begin
    if (bus0.cam_bram_wen) got0.push_back({bus0.cam_bram_waddr, bus0.cam_bram_wdata});
    if (bus2.cam_bram_wen) got2.push_back({bus2.cam_bram_waddr, bus2.cam_bram_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit which);
    tick();
    if (which) start2 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic fill_frame(input int lines, input int nbytes, input bit incrementing);
    int cnt = 0;
    for (int l = 0; l < lines; l++)
      for (int b = 0; b < nbytes; b++) begin
        frame_bytes[l][b] = incrementing ? 8'(cnt) : 8'($urandom);
        cnt++;
      end
  endtask

  task automatic vsync_pulse();
    tick();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drive_frame(input int lines, input int nbytes);
    vsync_pulse();
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < nbytes; b++) begin
        tick();
        href = 1'b1;
        data = frame_bytes[l][b];
      end
      tick();
      href = 1'b0;
      data = 8'($urandom);
      repeat (3) tick();
      if (l == mid_start_line) begin
        start0 = 1'b1;
        width = 9'd2;
        tick();
        start0 = 1'b0;
        tick();
        mid_busy = busy0;
      end
    end
    repeat (4) tick();
  endtask

  // expected writes straight from the crop rules: pixel (x,y) of the frame
  // lands at y*w + x if it lies inside the crop and below the BRAM depth
  task automatic build_expected(input int w, input int h, input int lines, input int nbytes, input int depth);
    int a;
    exp_q.delete();
    for (int yy = 0; yy < lines && yy < h; yy++)
      for (int xx = 0; xx < nbytes / 2 && xx < w; xx++) begin
        a = yy * w + xx;
        if (a < depth) exp_q.push_back({17'(a), frame_bytes[yy][2*xx], frame_bytes[yy][2*xx+1]});
      end
  endtask

  task automatic wait_done(input bit which, input int max_cycles);
    int n = 0;
    while (((which ? done2 : done0) !== 1'b1) && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy0, done0, bus0.cam_bram_wen} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags0: got %b expected 000", {busy0, done0, bus0.cam_bram_wen});
    end
    tests_run++;
    if ({bus0.cam_bram_waddr, bus0.cam_bram_wdata} !== 33'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus0: got %h expected 0", {bus0.cam_bram_waddr, bus0.cam_bram_wdata});
    end
    tests_run++;
    if ({busy2, done2, bus2.cam_bram_wen} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags2: got %b expected 000", {busy2, done2, bus2.cam_bram_wen});
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    width = 9'd4;
    height = 9'd3;
    got0.delete();
    pulse_start(1'b0);
    tests_run++;
    if ({busy0, done0} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL basic_start_flags: got busy/done %b expected 10", {busy0, done0});
    end
    fill_frame(6, 16, 1'b1);
    build_expected(4, 3, 6, 16, 131072);
    drive_frame(6, 16);
    vsync_pulse();
    wait_done(1'b0, 40);
    tests_run++;
    if (got0.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL basic_count: got %0d writes expected %0d", got0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got0.size(); i++) begin
      tests_run++;
      if (got0[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_write[%0d]: got addr %h data %h expected addr %h data %h",
                 i, got0[i][32:16], got0[i][15:0], exp_q[i][32:16], exp_q[i][15:0]);
      end
    end
    tests_run++;
    if (got0.size() == 0 || got0[0][15:0] !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL basic_first_pixel: got %0d writes, first expected 0001", got0.size());
    end
    tests_run++;
    if ({busy0, done0} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL basic_done_flags: got busy/done %b expected 01", {busy0, done0});
    end
  endtask

  // restart from DONE with width 3 and 5-pixel lines; a second start with
  // width 2 arrives mid-frame and must not disturb the capture
  task automatic test_start_in_done();
    width = 9'd3;
    height = 9'd3;
    got0.delete();
    pulse_start(1'b0);
    tests_run++;
    if ({busy0, done0} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL restart_flags: got busy/done %b expected 10", {busy0, done0});
    end
    fill_frame(4, 10, 1'b0);
    build_expected(3, 3, 4, 10, 131072);
    mid_start_line = 0;
    drive_frame(4, 10);
    mid_start_line = -1;
    tests_run++;
    if (mid_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_start_busy: got %b expected 1", mid_busy);
    end
    vsync_pulse();
    wait_done(1'b0, 40);
    tests_run++;
    if (got0.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL crop_count: got %0d writes expected %0d", got0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got0.size(); i++) begin
      tests_run++;
      if (got0[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL crop_write[%0d]: got addr %h data %h expected addr %h data %h",
                 i, got0[i][32:16], got0[i][15:0], exp_q[i][32:16], exp_q[i][15:0]);
      end
    end
    tests_run++;
    if (done0 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL crop_done: got %b expected 1", done0);
    end
  endtask

  task automatic test_odd_bytes();
    width = 9'd4;
    height = 9'd3;
    got0.delete();
    pulse_start(1'b0);
    fill_frame(4, 9, 1'b0);
    build_expected(4, 3, 4, 9, 131072);
    drive_frame(4, 9);
    vsync_pulse();
    wait_done(1'b0, 40);
    tests_run++;
    if (got0.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL odd_count: got %0d writes expected %0d", got0.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got0.size(); i++) begin
      tests_run++;
      if (got0[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL odd_write[%0d]: got addr %h data %h expected addr %h data %h",
                 i, got0[i][32:16], got0[i][15:0], exp_q[i][32:16], exp_q[i][15:0]);
      end
    end
  endtask

  task automatic test_width_zero();
    width = 9'd0;
    height = 9'd3;
    got0.delete();
    pulse_start(1'b0);
    fill_frame(4, 8, 1'b0);
    drive_frame(4, 8);
    tests_run++;
    if ({busy0, done0} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL zero_width_before_edge: got busy/done %b expected 10", {busy0, done0});
    end
    vsync_pulse();
    wait_done(1'b0, 40);
    tests_run++;
    if ({busy0, done0} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL zero_width_done: got busy/done %b expected 01", {busy0, done0});
    end
    tests_run++;
    if (got0.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL zero_width_writes: got %0d writes expected 0", got0.size());
    end
  endtask

  // dut2 skips two frames and has only 8 BRAM words, so of the 12 cropped
  // pixels only addresses 0..7 may be written
  task automatic test_skip_frames();
    width = 9'd4;
    height = 9'd3;
    got0.delete();
    got2.delete();
    pulse_start(1'b1);
    fill_frame(3, 8, 1'b0);
    drive_frame(3, 8);
    drive_frame(3, 8);
    tests_run++;
    if (got2.size() != 0 || busy2 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL skip_quiet: got %0d writes busy %b expected 0 writes busy 1", got2.size(), busy2);
    end
    fill_frame(3, 8, 1'b0);
    build_expected(4, 3, 3, 8, 8);
    drive_frame(3, 8);
    vsync_pulse();
    wait_done(1'b1, 40);
    tests_run++;
    if (got2.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL skip_count: got %0d writes expected %0d", got2.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got2.size(); i++) begin
      tests_run++;
      if (got2[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL skip_write[%0d]: got addr %h data %h expected addr %h data %h",
                 i, got2[i][32:16], got2[i][15:0], exp_q[i][32:16], exp_q[i][15:0]);
      end
    end
    tests_run++;
    if (done2 !== 1'b1 || got0.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL skip_done: got done %b idle writes %0d expected done 1, 0 writes", done2, got0.size());
    end
  endtask

  task automatic test_reset_mid_line();
    width = 9'd4;
    height = 9'd3;
    pulse_start(1'b0);
    fill_frame(3, 8, 1'b0);
    vsync_pulse();
    for (int b = 0; b < 5; b++) begin
      tick();
      href = 1'b1;
      data = frame_bytes[0][b];
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy0, done0, bus0.cam_bram_wen} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_flags: got %b expected 000", {busy0, done0, bus0.cam_bram_wen});
    end
    tests_run++;
    if ({bus0.cam_bram_waddr, bus0.cam_bram_wdata} !== 33'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_bus: got %h expected 0", {bus0.cam_bram_waddr, bus0.cam_bram_wdata});
    end
    href = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    got0.delete();
    drive_frame(3, 8);
    vsync_pulse();
    tests_run++;
    if (got0.size() != 0 || {busy0, done0} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_restart: got %0d writes busy/done %b expected 0 writes 00",
               got0.size(), {busy0, done0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_in_done();
    test_odd_bytes();
    test_width_zero();
    test_skip_frames();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
